multicast_fanout: RTL
=====================

Name: multicast_fanout

Overview:
- Counterpart of the collective reduction tree: takes one flit from the router core and replicates it to a selected subset of FAN_OUT output ports.
- Used for MPI broadcast/multicast in the 3D-torus router.
- Single-flit holding register; per-port copy issue is independent, so each port drains at its own pace under its own out_avail.
- Stall detection and a dropped-flit count are provided for collective-engine debug.

Parameters:
- FAN_OUT, 6, number of output ports (PORT_NUM).
- FLIT_SIZE, 82, flit width in bits.
- STALL_LIMIT, 100, cycles without any copy issued before stall asserts.
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in  input  FLIT_SIZE  incoming flit.
- in_valid  input  1  in/in_mask valid this cycle.
- in_mask  input  FAN_OUT  destination port bitmask for the flit.
- in_avail  output  1  block can accept a flit this cycle.
- out  output  FLIT_SIZE*FAN_OUT  per-port flit slices; port i is bits [i*FLIT_SIZE +: FLIT_SIZE].
- out_valid  output  FAN_OUT  per-port copy valid, one-cycle pulse per copy.
- out_avail  input  FAN_OUT  per-port downstream can take a copy this cycle.
- stall  output  1  held flit blocked for at least STALL_LIMIT cycles.
- drop_cnt  output  CNT_W  count of accepted flits with in_mask == 0.

Behaviour:
- Reset (rst = 0, async):
  - State = IDLE; hold register, pending mask and stall counter cleared.
  - out = 0, out_valid = 0, stall = 0, drop_cnt = 0.
  - A flit held when reset asserts is discarded.
- Handshake: a flit is accepted at a rising edge when in_valid and in_avail are both 1 in the preceding cycle.
- in_avail (combinational) = (state == IDLE) | ((pending & ~out_avail) == 0).
  - The slot frees in the same cycle its last copies issue, so back-to-back flits are accepted with no bubble.
- State machine:
  - IDLE: on accept with in_mask != 0, latch in into hold, latch pending = in_mask, go to REPLICATE.
  - IDLE, accept with in_mask == 0: flit dropped, drop_cnt += 1 (saturates at all-ones), stay IDLE.
  - REPLICATE: each cycle, issue = pending & out_avail.
    - At the edge: out_valid <= issue; for each set bit, out slice i <= hold; pending <= pending & ~issue.
    - If pending & ~issue == 0: go to IDLE, or stay in REPLICATE with the new flit/mask if a new accept (mask != 0) happens at the same edge.
    - Copies issued at that edge carry the old hold value; the new flit's copies start at the next edge at the earliest.
- out_valid is registered: latency is one cycle from the capture edge to the earliest out_valid for that flit.
- Unissued out slices hold their previous value.
- Each destination port receives exactly one copy per flit; no duplicates, no copy to a port with its mask bit clear.
- stall counter:
  - Increments each REPLICATE cycle with issue == 0; cleared on any issue and on entering IDLE.
  - stall = 1 when counter >= STALL_LIMIT; counter saturates at STALL_LIMIT.
  - stall stays 1 until the next issue or the flit completes.
- in_valid while in_avail = 0 is ignored. The upstream must hold the flit; the block does not latch it.

Test Plan:
- Reset with out_avail = 6'b111111, then in = 82'h1234, in_mask = 6'b000101, in_valid for 1 cycle -> one cycle after capture: out_valid = 6'b000101, slices 0 and 2 = 82'h1234; next cycle out_valid = 0, in_avail = 1.
- in_mask = 6'b111111, out_avail = 6'b000011 for 2 cycles, then 6'b111100 -> out_valid sequence 000011, 000000, 111100; in_avail = 0 until the cycle out_avail = 111100.
- Back-to-back: flits A (mask 6'b000001) and B (mask 6'b000010) on consecutive cycles, all out_avail high -> out_valid 000001 (A) then 000010 (B) on consecutive cycles, no bubble.
- in_mask = 6'b001000, out_avail[3] = 0 for 105 cycles -> stall rises 100 cycles after capture; out_avail[3] = 1 -> one copy issued, stall falls at the same edge.
- 3 accepted flits with in_mask = 0 -> drop_cnt = 3, out_valid never asserts, in_avail stays 1.
- Reset asserted mid-REPLICATE (pending = 6'b110000) -> out_valid, stall, drop_cnt go to 0 immediately; after release no copies of the old flit appear.

Source files
------------

// File: rtl/multicast_fanout.sv
// rtl/multicast_fanout.sv - replicates one held flit to a masked subset of output ports
module multicast_fanout #(
  parameter int FAN_OUT     = 6,
  parameter int FLIT_SIZE   = 82,
  parameter int STALL_LIMIT = 100,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_SIZE-1:0]         in,
  input  logic                         in_valid,
  input  logic [FAN_OUT-1:0]           in_mask,
  output logic                         in_avail,
  output logic [FLIT_SIZE*FAN_OUT-1:0] out,
  output logic [FAN_OUT-1:0]           out_valid,
  input  logic [FAN_OUT-1:0]           out_avail,
  output logic                         stall,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] REPLICATE = 1'b1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [0:0]           state;
  logic [FLIT_SIZE-1:0] hold;
  logic [FAN_OUT-1:0]   pending;
  logic [STALL_W-1:0]   stall_cnt;

  logic [FAN_OUT-1:0]   issue;
  logic [FAN_OUT-1:0]   remain;
  logic                 accept;
  logic                 slot_free;

  always_comb begin
    issue     = '0;
    remain    = pending & ~out_avail;
    if (state == REPLICATE) issue = pending & out_avail;
    // The slot frees in the same cycle its last copies leave, so a new flit needs no bubble
    slot_free = (state == IDLE) || (remain == '0);
    in_avail  = slot_free;
    accept    = in_valid && slot_free;
  end

  assign stall = (stall_cnt >= STALL_W'(STALL_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold      <= '0;
      pending   <= '0;
      stall_cnt <= '0;
      out       <= '0;
      out_valid <= '0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= issue;
      for (int i = 0; i < FAN_OUT; i++) begin
        if (issue[i]) out[i*FLIT_SIZE +: FLIT_SIZE] <= hold;
      end

      if (state == REPLICATE) begin
        pending <= remain;
        if (issue != '0) stall_cnt <= '0;
        else if (stall_cnt < STALL_W'(STALL_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
      end

      if (slot_free) begin
        state     <= IDLE;
        stall_cnt <= '0;
        if (accept) begin
          if (in_mask != '0) begin
            hold    <= in;
            pending <= in_mask;
            state   <= REPLICATE;
          end else if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
